// File: rtl/pm_pkg.sv
// Shared definitions for the ALU and its downstream accumulation stages.
package pm_pkg;

    // Op-codes decoded by the ALU; DPRO products feed dot_product_acc.
    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] MUL  = 3'b001;
    localparam logic [2:0] LDR  = 3'b100;
    localparam logic [2:0] STR  = 3'b101;
    localparam logic [2:0] MOV  = 3'b110;
    localparam logic [2:0] DPRO = 3'b111;

    localparam int unsigned DefaultDataW = 32;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StDone
    } acc_state_e;

endpackage

// File: rtl/sat_trunc.sv
// Signed saturating narrower: clamps an IN_W-bit value into OUT_W bits and flags clamping.
module sat_trunc #(
    parameter int unsigned IN_W  = 48,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  in_data,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    logic [IN_W-OUT_W:0] upper;
    logic                fits;

    // The value fits when every bit from the target sign bit upwards agrees.
    assign upper = in_data[IN_W-1:OUT_W-1];
    assign fits  = (&upper) | ~(|upper);

    always_comb begin
        out_data = in_data[OUT_W-1:0];
        out_ovf  = 1'b0;
        if (!fits) begin
            out_ovf  = 1'b1;
            out_data = in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/dot_product_acc.sv
// Sums vec_len signed ALU products and presents the saturated result on a valid/ready port.
module dot_product_acc
    import pm_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned ACC_W  = 48,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf,
    output logic              busy
);

    acc_state_e         state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   in_sext;

    assign in_sext = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = vec_len;
                    state_d = (vec_len == '0) ? StDone : StAcc;
                end
            end
            StAcc: begin
                // A beat coinciding with abort is dropped along with the operation.
                if (abort) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (in_valid) begin
                    acc_d = acc_q + in_sext;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (abort) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StAcc);
        out_valid = (state_q == StDone);
        busy      = (state_q == StAcc) || (state_q == StDone);
    end

    sat_trunc #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W)
    ) u_sat_trunc (
        .in_data  (acc_q),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

endmodule
